// File: rtl/sync_barrier_ctrl.sv
// sync_barrier_ctrl: responder end of the per-core sync barrier handshake.
// Collects barrier requests (with id) from the participating cores and pulses
// sync_enable back to all of them once every member has arrived with one id.
// Protocol errors (id mismatch, non-member request, timeout) are sticky.
module sync_barrier_ctrl #(
  parameter int N_CORES            = 4,
  parameter int SYNC_BARRIER_WIDTH = 8,
  parameter int TIMEOUT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES     = 40000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  mask_wr_en,
  input  logic [N_CORES-1:0]                    mask_in,
  input  logic [N_CORES-1:0]                    sync_en_in,
  input  logic [N_CORES*SYNC_BARRIER_WIDTH-1:0] sync_id_in,
  input  logic                                  err_clear,
  output logic [N_CORES-1:0]                    sync_enable,
  output logic [N_CORES-1:0]                    arrived,
  output logic                                  busy,
  output logic                                  err_id_mismatch,
  output logic                                  err_nonmember,
  output logic                                  err_timeout
);

  localparam int W = SYNC_BARRIER_WIDTH;
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_MAX  = {TIMEOUT_WIDTH{1'b1}};
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_ONE  = TIMEOUT_WIDTH'(1);
  localparam logic                     TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ERROR   = 2'd3
  } state_t;

  state_t                   state_r;
  logic [N_CORES-1:0]       mask_r;
  logic [N_CORES-1:0]       arrived_r;
  logic [N_CORES-1:0]       sync_enable_r;
  logic [N_CORES*W-1:0]     ids_r;
  logic [TIMEOUT_WIDTH-1:0] timer_r;
  logic                     busy_r;
  logic                     err_id_mismatch_r;
  logic                     err_nonmember_r;
  logic                     err_timeout_r;

  logic                     accept_s;
  logic [N_CORES-1:0]       new_arr_s;
  logic [N_CORES-1:0]       merged_s;
  logic [W-1:0]             ref_id_s;
  logic                     mismatch_s;
  logic                     nonmember_s;
  logic                     complete_s;
  logic                     timeout_s;

  // Id of the lowest-index core selected in sel (zero when none selected).
  function automatic logic [W-1:0] first_id(input logic [N_CORES-1:0] sel,
                                            input logic [N_CORES*W-1:0] ids);
    logic [W-1:0] id;
    id = {W{1'b0}};
    for (int i = N_CORES - 1; i >= 0; i--) begin
      id = sel[i] ? ids[i*W +: W] : id;
    end
    return id;
  endfunction

  // Decode this cycle's new arrivals, the round's reference id and completion/error conditions
  always_comb begin
    accept_s    = (state_r != ST_ERROR);
    new_arr_s   = accept_s ? (sync_en_in & mask_r & ~arrived_r) : {N_CORES{1'b0}};
    merged_s    = arrived_r | new_arr_s;
    nonmember_s = |(sync_en_in & ~mask_r);
    // Reference is the earliest arrival; on a fresh round the lowest-index new arrival.
    ref_id_s    = (|arrived_r) ? first_id(arrived_r, ids_r) : first_id(new_arr_s, sync_id_in);
    mismatch_s  = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      mismatch_s = mismatch_s | (new_arr_s[i] & (sync_id_in[i*W +: W] != ref_id_s));
    end
    complete_s  = ((merged_s & mask_r) == mask_r) && (|mask_r) && !mismatch_s;
    timeout_s   = TIMEOUT_EN && (state_r == ST_COLLECT) && (timer_r == TIMER_LAST);
  end

  // Barrier state machine with registered outputs and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      mask_r            <= {N_CORES{1'b0}};
      arrived_r         <= {N_CORES{1'b0}};
      sync_enable_r     <= {N_CORES{1'b0}};
      ids_r             <= {(N_CORES*W){1'b0}};
      timer_r           <= {TIMEOUT_WIDTH{1'b0}};
      busy_r            <= 1'b0;
      err_id_mismatch_r <= 1'b0;
      err_nonmember_r   <= 1'b0;
      err_timeout_r     <= 1'b0;
    end else begin
      // A new error event in the same cycle as err_clear stays visible.
      err_id_mismatch_r <= (err_clear ? 1'b0 : err_id_mismatch_r) | mismatch_s;
      err_nonmember_r   <= (err_clear ? 1'b0 : err_nonmember_r) | nonmember_s;
      err_timeout_r     <= (err_clear ? 1'b0 : err_timeout_r) | (timeout_s && !complete_s);
      sync_enable_r     <= {N_CORES{1'b0}};
      for (int i = 0; i < N_CORES; i++) begin
        if (new_arr_s[i]) begin
          ids_r[i*W +: W] <= sync_id_in[i*W +: W];
        end
      end
      case (state_r)
        // RELEASE behaves like IDLE so requests arriving during the pulse open the next round.
        ST_IDLE, ST_RELEASE: begin
          if ((state_r == ST_IDLE) && mask_wr_en) begin
            mask_r <= mask_in;
          end
          timer_r <= {TIMEOUT_WIDTH{1'b0}};
          if (mismatch_s) begin
            state_r   <= ST_ERROR;
            arrived_r <= merged_s;
            busy_r    <= 1'b1;
          end else if (complete_s) begin
            state_r       <= ST_RELEASE;
            sync_enable_r <= mask_r;
            arrived_r     <= {N_CORES{1'b0}};
            busy_r        <= 1'b1;
          end else if (|new_arr_s) begin
            state_r   <= ST_COLLECT;
            arrived_r <= merged_s;
            busy_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_COLLECT: begin
          busy_r <= 1'b1;
          if (mismatch_s) begin
            state_r   <= ST_ERROR;
            arrived_r <= merged_s;
          end else if (complete_s) begin
            state_r       <= ST_RELEASE;
            sync_enable_r <= mask_r;
            arrived_r     <= {N_CORES{1'b0}};
          end else if (timeout_s) begin
            state_r   <= ST_ERROR;
            arrived_r <= merged_s;
          end else begin
            arrived_r <= merged_s;
            timer_r   <= (timer_r == TIMER_MAX) ? timer_r : (timer_r + TIMER_ONE);
          end
        end
        ST_ERROR: begin
          if (err_clear) begin
            state_r   <= ST_IDLE;
            arrived_r <= {N_CORES{1'b0}};
            busy_r    <= 1'b0;
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          arrived_r <= {N_CORES{1'b0}};
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign sync_enable     = sync_enable_r;
  assign arrived         = arrived_r;
  assign busy            = busy_r;
  assign err_id_mismatch = err_id_mismatch_r;
  assign err_nonmember   = err_nonmember_r;
  assign err_timeout     = err_timeout_r;

endmodule
